// File: rtl/pueo_beam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pueo_beam_pkg                                                         |
// | Shared helpers for the multi-beam power trigger: sample centering,    |
// | power-width sizing, ceil-log2 and the packed index into beam_i.       |
// | No ports (package).                                                   |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package pueo_beam_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Ceiling log2 with a floor of 1, for select/counter widths.
  function automatic int clog2_min1(input longint v);
    int r;
    r = clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Offset-binary sample to odd, zero-centred value: 2x - (2^nbits - 1).
  function automatic int center(input int x, input int nbits);
    return 2 * x - ((1 << nbits) - 1);
  endfunction

  // Width needed for the largest possible power nsamp * (nchan*(2^nbits-1))^2 / 4.
  function automatic int pwr_width(input int nchan, input int nsamp, input int nbits);
    longint m;
    m = longint'(nchan) * ((longint'(1) << nbits) - 1);
    return clog2((longint'(nsamp) * m * m) / 4 + 1);
  endfunction

  // Bit offset of sample [b][c][s] inside the flattened beam vector.
  function automatic int beam_idx(input int b, input int c, input int s,
                                  input int nchan, input int nsamp, input int nbits);
    return nbits * (nsamp * (nchan * b + c) + s);
  endfunction

endpackage : pueo_beam_pkg
`default_nettype wire

// File: rtl/pueo_beam_power.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pueo_beam_power                                                       |
// | Three-stage power computation for a single beam:                      |
// |   stage 1: S = sum over channels of centred samples                   |
// |   stage 2: (S/2)^2 per sample (S is even, so the halving is exact)    |
// |   stage 3: sum over samples                                           |
// | Ports:                                                                |
// |   clk_i    in   clock                                                 |
// |   rst_n_i  in   asynchronous active-low reset                         |
// |   samp_i   in   NCHAN*NSAMP*NBITS samples, [chan][samp] packing       |
// |   power_o  out  PW-bit registered power                               |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module pueo_beam_power
  import pueo_beam_pkg::*;
#(
  parameter int NCHAN = 8,
  parameter int NSAMP = 8,
  parameter int NBITS = 5,
  parameter int PW    = pwr_width(NCHAN, NSAMP, NBITS)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NCHAN*NSAMP*NBITS-1:0] samp_i,
  output logic [PW-1:0]                power_o
);

  localparam int DW = NBITS + 1;          // centred sample width
  localparam int SW = DW + clog2(NCHAN);  // channel-sum width
  localparam int EW = (PW > SW) ? PW : SW;

  logic signed [SW-1:0] sum_d [NSAMP];
  logic signed [SW-1:0] sum_q [NSAMP];
  logic        [PW-1:0] sq_d  [NSAMP];
  logic        [PW-1:0] sq_q  [NSAMP];
  logic        [PW-1:0] pwr_d;
  logic        [PW-1:0] pwr_q;
  logic signed [SW-1:0] half;
  logic        [SW-1:0] mag;

  // Stage 1 combinational: channel sum of centred samples.
  always_comb begin
    for (int s = 0; s < NSAMP; s++) begin
      sum_d[s] = '0;
      for (int c = 0; c < NCHAN; c++) begin
        sum_d[s] = sum_d[s] +
          SW'(center(int'(samp_i[beam_idx(0, c, s, NCHAN, NSAMP, NBITS) +: NBITS]), NBITS));
      end
    end
  end

  // Stage 2 combinational: S^2/4 as (S/2)^2 on the magnitude.
  always_comb begin
    half = '0;
    mag  = '0;
    for (int s = 0; s < NSAMP; s++) begin
      half    = sum_q[s] >>> 1;
      mag     = half[SW-1] ? SW'(-half) : SW'(half);
      sq_d[s] = PW'(EW'(mag) * EW'(mag));
    end
  end

  // Stage 3 combinational: sum over samples.
  always_comb begin
    pwr_d = '0;
    for (int s = 0; s < NSAMP; s++) begin
      pwr_d = pwr_d + sq_q[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < NSAMP; s++) begin
        sum_q[s] <= '0;
        sq_q[s]  <= '0;
      end
      pwr_q <= '0;
    end else begin
      for (int s = 0; s < NSAMP; s++) begin
        sum_q[s] <= sum_d[s];
        sq_q[s]  <= sq_d[s];
      end
      pwr_q <= pwr_d;
    end
  end

  assign power_o = pwr_q;

endmodule : pueo_beam_power
`default_nettype wire

// File: rtl/multi_pueo_beam.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_pueo_beam                                                       |
// | NBEAMS parallel beam power triggers with double-buffered thresholds,  |
// | per-beam holdoff, mask and saturating trigger scalers.                |
// | Ports:                                                                |
// |   clk_i, rst_n_i   clock, asynchronous active-low reset               |
// |   beam_i           samples [beam][chan][samp]                         |
// |   thresh_i/_addr_i/_wr_i  shadow threshold write                      |
// |   update_i         copy all shadow thresholds to active               |
// |   mask_i           per-beam trigger inhibit                           |
// |   trigger_o        per-beam one-cycle trigger pulse                   |
// |   count_sel_i/count_o/count_clr_i  scaler readback and clear          |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module multi_pueo_beam
  import pueo_beam_pkg::*;
#(
  parameter int NBEAMS  = 2,
  parameter int NCHAN   = 8,
  parameter int NSAMP   = 8,
  parameter int NBITS   = 5,
  parameter int TWIDTH  = 18,
  parameter int HOLDOFF = 16,
  parameter int CWIDTH  = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0] beam_i,
  input  logic [TWIDTH-1:0]                   thresh_i,
  input  logic [clog2_min1(NBEAMS)-1:0]       thresh_addr_i,
  input  logic                                thresh_wr_i,
  input  logic                                update_i,
  input  logic [NBEAMS-1:0]                   mask_i,
  output logic [NBEAMS-1:0]                   trigger_o,
  input  logic [clog2_min1(NBEAMS)-1:0]       count_sel_i,
  output logic [CWIDTH-1:0]                   count_o,
  input  logic                                count_clr_i
);

  localparam int BW = NCHAN * NSAMP * NBITS;
  localparam int PW = pwr_width(NCHAN, NSAMP, NBITS);
  localparam int HW = clog2_min1(HOLDOFF + 1);

  if (PW > TWIDTH) begin : g_pw_check
    $error("multi_pueo_beam: power width exceeds TWIDTH");
  end

  if ((NCHAN % 2) != 0) begin : g_nchan_check
    $error("multi_pueo_beam: NCHAN must be even");
  end

  logic [PW-1:0]     power    [NBEAMS];
  logic [TWIDTH-1:0] shadow_q [NBEAMS];
  logic [TWIDTH-1:0] active_q [NBEAMS];
  logic [HW-1:0]     hold_q   [NBEAMS];
  logic [CWIDTH-1:0] scaler_q [NBEAMS];
  logic [NBEAMS-1:0] fire;
  logic [NBEAMS-1:0] trig_q;
  logic [CWIDTH-1:0] count_q;

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    pueo_beam_power #(
      .NCHAN (NCHAN),
      .NSAMP (NSAMP),
      .NBITS (NBITS),
      .PW    (PW)
    ) u_power (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .samp_i  (beam_i[b*BW +: BW]),
      .power_o (power[b])
    );
  end

  // A masked beam never fires, so its holdoff and scaler stay untouched.
  always_comb begin
    fire = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      fire[b] = (TWIDTH'(power[b]) > active_q[b]) && !mask_i[b] && (hold_q[b] == '0);
    end
  end

  // Update copies the pre-write shadow; a same-cycle write lands afterwards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadow_q[b] <= '1;
        active_q[b] <= '1;
      end
    end else begin
      if (update_i) begin
        for (int b = 0; b < NBEAMS; b++) begin
          active_q[b] <= shadow_q[b];
        end
      end
      if (thresh_wr_i && (int'(thresh_addr_i) < NBEAMS)) begin
        shadow_q[thresh_addr_i] <= thresh_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        hold_q[b]   <= '0;
        scaler_q[b] <= '0;
      end
      trig_q  <= '0;
      count_q <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (fire[b]) begin
          hold_q[b] <= HW'(HOLDOFF);
        end else if (hold_q[b] != '0) begin
          hold_q[b] <= hold_q[b] - HW'(1);
        end
        if (count_clr_i) begin
          scaler_q[b] <= '0;
        end else if (fire[b] && (scaler_q[b] != '1)) begin
          scaler_q[b] <= scaler_q[b] + CWIDTH'(1);
        end
      end
      trig_q  <= fire;
      count_q <= (int'(count_sel_i) < NBEAMS) ? scaler_q[count_sel_i] : '0;
    end
  end

  assign trigger_o = trig_q;
  assign count_o   = count_q;

endmodule : multi_pueo_beam
`default_nettype wire

// File: tb/tb_multi_pueo_beam.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_pueo_beam                                                    |
// | Directed and randomised stimulus for multi_pueo_beam, checked every   |
// | cycle against a behavioural model plus targeted scenario checks.      |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_multi_pueo_beam;

  localparam int NB = 2;
  localparam int NC = 8;
  localparam int NS = 8;
  localparam int NBI = 5;
  localparam int TW = 18;
  localparam int HO = 16;
  localparam int CW = 16;
  localparam int TMAX = (1 << TW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NB*NC*NS*NBI-1:0]  beam = '0;
  logic [TW-1:0]            thresh = '0;
  logic                     thresh_addr = 1'b0;
  logic                     thresh_wr = 1'b0;
  logic                     update = 1'b0;
  logic [NB-1:0]            mask = '0;
  logic [NB-1:0]            trigger;
  logic                     count_sel = 1'b0;
  logic [CW-1:0]            count;
  logic                     count_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int pd0 [NB];
  int pd1 [NB];
  int pd2 [NB];
  int shadow [NB];
  int active [NB];
  int hold [NB];
  int scal [NB];
  int m_trig;
  int m_count;

  multi_pueo_beam dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .beam_i        (beam),
    .thresh_i      (thresh),
    .thresh_addr_i (thresh_addr),
    .thresh_wr_i   (thresh_wr),
    .update_i      (update),
    .mask_i        (mask),
    .trigger_o     (trigger),
    .count_sel_i   (count_sel),
    .count_o       (count),
    .count_clr_i   (count_clr)
  );

  always #5 clk = ~clk;

  function automatic int ref_power(input int b);
    int p;
    int sum;
    int x;
    p = 0;
    for (int s = 0; s < NS; s++) begin
      sum = 0;
      for (int c = 0; c < NC; c++) begin
        x = int'(beam[NBI*(NS*(NC*b+c)+s) +: NBI]);
        sum += 2 * x - ((1 << NBI) - 1);
      end
      p += (sum * sum) / 4;
    end
    return p;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      pd0[b] = 0; pd1[b] = 0; pd2[b] = 0;
      shadow[b] = TMAX; active[b] = TMAX;
      hold[b] = 0; scal[b] = 0;
    end
    m_trig = 0;
    m_count = 0;
  endtask

  function automatic bit will_fire(input int b);
    return (pd2[b] > active[b]) && !mask[b] && (hold[b] == 0);
  endfunction

  task automatic model_edge();
    int f [NB];
    for (int b = 0; b < NB; b++) f[b] = will_fire(b) ? 1 : 0;
    m_count = scal[count_sel];
    m_trig = 0;
    for (int b = 0; b < NB; b++) begin
      if (f[b] != 0) hold[b] = HO;
      else if (hold[b] > 0) hold[b] = hold[b] - 1;
      if (count_clr) scal[b] = 0;
      else if ((f[b] != 0) && (scal[b] < CMAX)) scal[b] = scal[b] + 1;
      if (f[b] != 0) m_trig = m_trig | (1 << b);
    end
    if (update) for (int b = 0; b < NB; b++) active[b] = shadow[b];
    if (thresh_wr) shadow[thresh_addr] = int'(thresh);
    for (int b = 0; b < NB; b++) begin
      pd2[b] = pd1[b];
      pd1[b] = pd0[b];
      pd0[b] = ref_power(b);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("trigger", int'(trigger), m_trig);
    check("count", int'(count), m_count);
  endtask

  task automatic write_thresh(input int b, input int v);
    thresh_addr = b[0];
    thresh = TW'(v);
    thresh_wr = 1'b1;
    tick();
    thresh_wr = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic set_sample(input int b, input int c, input int s, input int v);
    beam[NBI*(NS*(NC*b+c)+s) +: NBI] = NBI'(v);
  endtask

  task automatic set_all(input int v);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < NS; s++) set_sample(b, c, s, v);
  endtask

  // Alternating 15/16 across channels cancels to zero power.
  task automatic set_quiet();
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < NS; s++) set_sample(b, c, s, (c % 2 == 0) ? 15 : 16);
  endtask

  task automatic set_mixed();
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < NS; s++) set_sample(b, c, s, (s < 4) ? 15 : 16);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_trigger", int'(trigger), 0);
    check("reset_count", int'(count), 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    int n1;
    int gap;
    bit seen;

    model_reset();
    set_quiet();
    apply_reset();
    tick();

    // Threshold load, latency and holdoff period
    write_thresh(0, 127);
    write_thresh(1, 128);
    do_update();
    for (int k = 0; k < 4; k++) tick();
    set_all(15);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("latency", int'(trigger), (k == 4) ? 1 : 0);
    end
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!trigger[0] && gap < 40);
    check("period", gap, HO + 1);

    // Write without update
    write_thresh(1, TMAX);
    do_update();
    set_all(31);
    write_thresh(1, 0);
    n1 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n1 += int'(trigger[1]);
    end
    check("no_update_silent", n1, 0);
    do_update();
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (trigger[1]) seen = 1'b1;
    end
    check("update_fires", int'(seen), 1);

    // Mixed samples at the strict boundary
    write_thresh(0, 128);
    write_thresh(1, 128);
    do_update();
    set_mixed();
    for (int k = 0; k < 20; k++) tick();
    n0 = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      n0 += int'(trigger[0]) + int'(trigger[1]);
    end
    check("equal_no_fire", n0, 0);
    write_thresh(0, 127);
    write_thresh(1, 127);
    do_update();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n0 += int'(trigger[0]);
      n1 += int'(trigger[1]);
    end
    check("above_fire_b0", int'(n0 > 0), 1);
    check("above_fire_b1", int'(n1 > 0), 1);

    // Mask
    mask = 2'b01;
    tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n0 += int'(trigger[0]);
      n1 += int'(trigger[1]);
    end
    check("mask_b0_silent", n0, 0);
    check("mask_b1_fires", int'(n1 >= 2), 1);
    count_sel = 1'b0;
    tick();
    tick();
    check("mask_scaler", int'(count), 0);
    mask = 2'b00;

    // Scaler count and clear priority
    count_sel = 1'b1;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    n1 = 0; gap = 0;
    while (n1 < 3 && gap < 100) begin
      tick();
      n1 += int'(trigger[1]);
      gap++;
    end
    check("three_triggers", n1, 3);
    tick();
    check("scaler_three", int'(count), 3);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (will_fire(1)) begin
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check("clr_coincident_trig", int'(trigger[1]), 1);
        seen = 1'b1;
      end else begin
        tick();
      end
    end
    check("clr_window", int'(seen), 1);
    tick();
    check("clr_priority", int'(count), 0);

    // Reset mid-holdoff
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!trigger[0] && gap < 40);
    check("pre_reset_trigger", int'(trigger[0]), 1);
    tick(); tick(); tick();
    apply_reset();
    n0 = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n0 += int'(trigger[0]) + int'(trigger[1]);
    end
    check("post_reset_silent", n0, 0);
    set_all(31);
    write_thresh(0, 127);
    write_thresh(1, 127);
    do_update();
    n0 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n0 += int'(trigger[0]) + int'(trigger[1]);
    end
    check("reload_fires", int'(n0 > 0), 1);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < NB; b++)
        for (int c = 0; c < NC; c++)
          for (int s = 0; s < NS; s++) set_sample(b, c, s, int'($urandom_range(12, 19)));
      thresh_wr   = ($urandom_range(0, 3) == 0);
      thresh_addr = 1'($urandom_range(0, 1));
      thresh      = TW'($urandom_range(0, 800));
      update      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mask = 2'($urandom_range(0, 3));
      count_sel   = 1'($urandom_range(0, 1));
      count_clr   = ($urandom_range(0, 31) == 0);
      tick();
    end
    thresh_wr = 1'b0;
    update = 1'b0;
    count_clr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multi_pueo_beam
`default_nettype wire
